// File: rtl/alu_byte_sequencer_if.sv
// Byte-wide bus between the multi-precision sequencer and the two-slice 74181 ALU.
// The master drives operands, function select and carry; the slave returns F, Cn+8 and A=B.
interface alu_byte_sequencer_if;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_s;
  logic       alu_m;
  logic       alu_cn;
  logic [7:0] alu_f;
  logic       alu_cn8;
  logic       alu_eq;

  modport master (
    output alu_a, alu_b, alu_s, alu_m, alu_cn,
    input  alu_f, alu_cn8, alu_eq
  );

  modport slave (
    input  alu_a, alu_b, alu_s, alu_m, alu_cn,
    output alu_f, alu_cn8, alu_eq
  );
endinterface

// File: rtl/alu_byte_sequencer.sv
// Multi-precision controller: drives one byte pair per clock into an 8-bit 74181 ALU and chains the carry.
// Optional macro ALU_SEQ_EQUAL_EN builds the accumulated A=B flag; otherwise all_equal is tied low.
module alu_byte_sequencer #(
  parameter int NUM_BYTES = 4,
  parameter int LEN_W     = $clog2(NUM_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   op_cin,
  input  logic [LEN_W-1:0]       len,
  input  logic [8*NUM_BYTES-1:0] opa,
  input  logic [8*NUM_BYTES-1:0] opb,
  alu_byte_sequencer_if.master   alu,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] result,
  output logic                   cout,
  output logic                   all_equal
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic                   cq_q, cq_d;
  logic [3:0]             s_q, s_d;
  logic                   m_q, m_d;
  logic [8*NUM_BYTES-1:0] result_q, result_d;
  logic [8*NUM_BYTES-1:0] opa_q, opb_q;
  logic [LEN_W-1:0]       len_q;
  logic                   load;
  logic                   is_last;
  logic [LEN_W+2:0]       bit_ofs;

  assign is_last = (idx_q == len_q);
  assign bit_ofs = {idx_q, 3'b000};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cq_d     = cq_q;
    s_d      = s_q;
    m_d      = m_q;
    result_d = result_q;
    load     = 1'b0;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            load     = 1'b1;
            s_d      = op_s;
            m_d      = op_m;
            cq_d     = op_cin;
            idx_d    = '0;
            result_d = '0;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          result_d[bit_ofs +: 8] = alu.alu_f;
          cq_d                   = alu.alu_cn8;
          // Hold idx on the last byte so len = NUM_BYTES-1 never wraps the index.
          idx_d   = is_last ? idx_q : idx_q + 1'b1;
          state_d = is_last ? ST_DONE : ST_RUN;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cq_q     <= 1'b1;
      s_q      <= 4'h0;
      m_q      <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cq_q     <= cq_d;
      s_q      <= s_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  // Operand latches are only observed while in RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      opa_q <= opa;
      opb_q <= opb;
      len_q <= len;
    end
  end

`ifdef ALU_SEQ_EQUAL_EN
  logic all_eq_q, all_eq_d;

  always_comb begin
    all_eq_d = all_eq_q;
    if (ena) begin
      if (state_q == ST_IDLE && start) all_eq_d = 1'b1;
      else if (state_q == ST_RUN)      all_eq_d = all_eq_q & alu.alu_eq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_eq_q <= 1'b0;
    else        all_eq_q <= all_eq_d;
  end

  assign all_equal = all_eq_q;
`else
  logic unused_alu_eq;
  assign unused_alu_eq = alu.alu_eq;
  assign all_equal     = 1'b0;
`endif

  assign alu.alu_a  = (state_q == ST_RUN) ? opa_q[bit_ofs +: 8] : 8'h00;
  assign alu.alu_b  = (state_q == ST_RUN) ? opb_q[bit_ofs +: 8] : 8'h00;
  assign alu.alu_s  = s_q;
  assign alu.alu_m  = m_q;
  assign alu.alu_cn = cq_q;

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cq_q;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Bench for alu_byte_sequencer: behavioural 74181 byte slice on the ALU bus, wide-arithmetic reference.
// Honours ALU_SEQ_EQUAL_EN when forming the expected all_equal value.
module tb_alu_byte_sequencer;
  localparam int NB = 4;
  localparam int LW = $clog2(NB);
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    op_s = 4'h0;
  logic          op_m = 1'b0;
  logic          op_cin = 1'b1;
  logic [LW-1:0] len = '0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic          busy, done, cout, all_equal;
  logic [W-1:0]  result;

  int checks = 0;
  int errors = 0;

  alu_byte_sequencer_if alu_if ();

  alu_byte_sequencer #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .op_s      (op_s),
    .op_m      (op_m),
    .op_cin    (op_cin),
    .len       (len),
    .opa       (opa),
    .opb       (opb),
    .alu       (alu_if),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .all_equal (all_equal)
  );

  always #5 clk = ~clk;

  // 74181 logic-mode functions (active-high data), usable at any width up to 64 bits.
  function automatic logic [63:0] lfn(input logic [3:0] s, input logic [63:0] a, input logic [63:0] b);
    case (s)
      4'h0: lfn = ~a;
      4'h1: lfn = ~(a | b);
      4'h2: lfn = ~a & b;
      4'h3: lfn = 64'd0;
      4'h4: lfn = ~(a & b);
      4'h5: lfn = ~b;
      4'h6: lfn = a ^ b;
      4'h7: lfn = a & ~b;
      4'h8: lfn = ~a | b;
      4'h9: lfn = ~(a ^ b);
      4'hA: lfn = b;
      4'hB: lfn = a & b;
      4'hC: lfn = {64{1'b1}};
      4'hD: lfn = a | ~b;
      4'hE: lfn = a | b;
      default: lfn = a;
    endcase
  endfunction

  // Combinational ALU slice pair: arithmetic is (A | B.S0 | ~B.S1) plus (A.~B.S2 | A.B.S3) plus carry.
  logic [7:0]  m_t1, m_t2, m_f;
  logic [8:0]  m_sum;
  logic [63:0] m_l64;
  always_comb begin
    m_t1  = alu_if.alu_a | (alu_if.alu_b & {8{alu_if.alu_s[0]}}) | (~alu_if.alu_b & {8{alu_if.alu_s[1]}});
    m_t2  = (alu_if.alu_a & ~alu_if.alu_b & {8{alu_if.alu_s[2]}}) | (alu_if.alu_a & alu_if.alu_b & {8{alu_if.alu_s[3]}});
    m_sum = {1'b0, m_t1} + {1'b0, m_t2} + {8'd0, ~alu_if.alu_cn};
    m_l64 = lfn(alu_if.alu_s, {56'd0, alu_if.alu_a}, {56'd0, alu_if.alu_b});
    m_f   = alu_if.alu_m ? m_l64[7:0] : m_sum[7:0];
  end
  assign alu_if.alu_f   = m_f;
  assign alu_if.alu_cn8 = ~m_sum[8];
  assign alu_if.alu_eq  = (m_f == 8'hFF);

  // Whole-operation reference at full operand width, no byte chaining.
  task automatic ref_op(input logic [3:0] s, input logic m, input logic cin, input int ln,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] r, output logic co, output logic eq);
    int w;
    logic [63:0] mask, am, bm, t1, t2, sum;
    w    = 8 * (ln + 1);
    mask = (64'd1 << w) - 64'd1;
    am   = a & mask;
    bm   = b & mask;
    t1   = am | (bm & {64{s[0]}}) | (~bm & mask & {64{s[1]}});
    t2   = (am & ~bm & {64{s[2]}}) | (am & bm & {64{s[3]}});
    sum  = t1 + t2 + {63'd0, ~cin};
    co   = ~sum[w];
    r    = m ? (lfn(s, am, bm) & mask) : (sum & mask);
`ifdef ALU_SEQ_EQUAL_EN
    eq   = (r == mask);
`else
    eq   = 1'b0;
`endif
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: extra start pulse during RUN, 2: ena low for 3 cycles mid-RUN.
  task automatic run_op(input string tag, input logic [3:0] s, input logic m, input logic cin,
                        input int ln, input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    logic [63:0] er;
    logic eco, eeq;
    int cyc, exp_lat;
    ref_op(s, m, cin, ln, 64'(a), 64'(b), er, eco, eeq);
    exp_lat = ln + 2 + ((mode == 2) ? 3 : 0);
    op_s = s; op_m = m; op_cin = cin; len = LW'(ln); opa = a; opb = b;
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " alu_s"}, 64'(alu_if.alu_s), 64'(s));
        check({tag, " alu_m"}, 64'(alu_if.alu_m), 64'(m));
      end
      if (mode == 1 && cyc == 2) begin start = 1'b1; opa = ~a; opb = ~b; op_s = ~s; op_m = ~m; end
      if (mode == 1 && cyc == 3) start = 1'b0;
      if (mode == 2 && cyc == 2) ena = 1'b0;
      if (mode == 2 && cyc == 5) ena = 1'b1;
    end while (!done && cyc < 40);
    check({tag, " done"},    64'(done), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " result"},  64'(result), er);
    check({tag, " cout"},    64'(cout), 64'(eco));
    check({tag, " all_eq"},  64'(all_equal), 64'(eeq));
    @(posedge clk); #1;
    check({tag, " done_off"}, 64'(done), 64'd0);
    check({tag, " idle"},     64'(busy), 64'd0);
    check({tag, " hold"},     64'(result), er);
  endtask

  initial begin
    logic [63:0] er;
    logic eco, eeq;
    int n;

    #12;
    check("rst busy",   64'(busy), 64'd0);
    check("rst done",   64'(done), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst cout",   64'(cout), 64'd1);
    check("rst alu_cn", 64'(alu_if.alu_cn), 64'd1);
    check("rst all_eq", 64'(all_equal), 64'd0);
    check("rst alu_a",  64'(alu_if.alu_a), 64'd0);
    check("rst alu_b",  64'(alu_if.alu_b), 64'd0);
    check("rst alu_s",  64'(alu_if.alu_s), 64'd0);
    check("rst alu_m",  64'(alu_if.alu_m), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add",      4'b1001, 1'b0, 1'b1, 3, 32'h0000_00FF, 32'h0000_0001, 0);
    check("add value", 64'(result), 64'h0000_0100);
    run_op("add_ovf",  4'b1001, 1'b0, 1'b1, 3, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    check("ovf cout",  64'(cout), 64'd0);
    run_op("eq_same",  4'b0110, 1'b0, 1'b1, 1, 32'h0000_1234, 32'h0000_1234, 0);
    check("eq value",  64'(result), 64'h0000_FFFF);
    run_op("eq_diff",  4'b0110, 1'b0, 1'b1, 1, 32'h0000_1234, 32'h0000_1235, 0);
    run_op("xor",      4'b0110, 1'b1, 1'b1, 0, 32'h0000_00A5, 32'h0000_00FF, 0);
    check("xor value", 64'(result), 64'h0000_005A);
    run_op("upper0",   4'b1001, 1'b0, 1'b0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("restart",  4'b1001, 1'b0, 1'b1, 3, 32'h1111_2222, 32'h0303_0404, 1);
    run_op("ena_gap",  4'b0110, 1'b0, 1'b0, 3, 32'h8765_4321, 32'h1234_5678, 2);

    // Asynchronous reset in the middle of an operation.
    op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b1; len = LW'(3); opa = 32'h0102_0304; opb = 32'h0506_0708;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midrst pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy",   64'(busy), 64'd0);
    check("midrst result", 64'(result), 64'd0);
    check("midrst done",   64'(done), 64'd0);
    check("midrst cout",   64'(cout), 64'd1);
    check("midrst alu_a",  64'(alu_if.alu_a), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst stay_idle", 64'(busy), 64'd0);

    // start held high: done pulses repeat every len+3 cycles.
    op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b1; len = LW'(2); opa = 32'h00AB_CDEF; opb = 32'h0011_1111;
    ref_op(4'b1001, 1'b0, 1'b1, 2, 64'h00AB_CDEF, 64'h0011_1111, er, eco, eeq);
    start = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 40);
    check("b2b first_lat", 64'(n), 64'd4);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 40);
    check("b2b period", 64'(n), 64'd5);
    check("b2b result", 64'(result), er);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b idle", 64'(busy), 64'd0);

    for (int i = 0; i < 30; i++) begin
      logic [3:0]   rs;
      logic         rm, rc;
      logic [W-1:0] ra, rb;
      int           rl;
      rs = 4'($urandom);
      rm = 1'($urandom);
      rc = 1'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      rl = int'($urandom_range(0, NB - 1));
      run_op("rand", rs, rm, rc, rl, ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_byte_sequencer.md
# alu_byte_sequencer

Multi-precision controller for the 8-bit two-slice 74181 ALU datapath. It latches wide operands and an operation code, then drives one byte pair per clock into the ALU. Each cycle it captures the 8-bit result and the ripple carry, and feeds that carry back into the next byte. The result is an arithmetic or logic operation up to `8*NUM_BYTES` bits wide. It sits between the SPI register bank and the ALU instances, replacing the direct config-register-to-ALU wiring.

## Interface
Parameters:
- `NUM_BYTES`, default 4: maximum operand width in bytes. Must be a power of two, ≥2.
- `LEN_W`, default `$clog2(NUM_BYTES)`: width of `len`.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  clock enable. When low, all state holds.
- `start`  in  1  request. Sampled only in IDLE with `ena`=1.
- `op_s`  in  4  74181 function select S3..S0.
- `op_m`  in  1  mode. 1 = logic, 0 = arithmetic.
- `op_cin`  in  1  initial carry into byte 0. Active-low, same as 74181 Cn.
- `len`  in  LEN_W  number of bytes minus 1.
- `opa`, `opb`  in  8*NUM_BYTES  operands. Byte 0 is the LSB.
- `alu_a`, `alu_b`  out  8  byte currently presented to the ALU.
- `alu_s`  out  4  function select to the ALU.
- `alu_m`  out  1  mode to the ALU.
- `alu_cn`  out  1  carry into the ALU.
- `alu_f`  in  8  ALU result.
- `alu_cn8`  in  1  carry out of the upper slice.
- `alu_eq`  in  1  AND of both slices' A=B outputs.
- `busy`  out  1  high from the cycle after `start` is accepted until return to IDLE.
- `done`  out  1  one-cycle pulse; result is valid.
- `result`  out  8*NUM_BYTES  assembled result.
- `cout`  out  1  final captured carry. Active-low.
- `all_equal`  out  1  A=B flag accumulated across bytes.

## Operation
States:
- **IDLE**
  - On `start`: latch `opa`, `opb`, `op_s`, `op_m`, `len`.
  - Set carry register `cq` ← `op_cin`, byte index `idx` ← 0.
  - Clear `result` to 0 and set `all_equal` ← 1.
  - Go to RUN.
- **RUN**
  - Drive `alu_a`/`alu_b` = latched byte `idx`, and `alu_cn` = `cq`.
  - Each enabled edge:
    - `result[8*idx+:8]` ← `alu_f`
    - `cq` ← `alu_cn8`
    - `all_equal` ← `all_equal & alu_eq`
    - `idx` ← `idx+1`
  - When `idx==len` on that edge, go to DONE.
- **DONE**
  - `done`=1 for this single state cycle.
  - Next enabled edge → IDLE.

Output rules:
- `alu_s`/`alu_m` always reflect the latched op.
- `alu_a`/`alu_b` are 0 outside RUN.
- `alu_cn` = `cq` in all states.
- `cout` = `cq`. It is valid in DONE and holds until the next accepted `start`.
- `result` and `all_equal` hold until the next accepted `start`.

Carry handling:
- Carry is passed through without inversion, using 74181 active-high-data convention.
- Carry is captured in logic mode too. It is meaningless there, and software ignores it.

Boundary conditions:
- `start` while `busy`: ignored. No latching occurs.
- `start` held high through DONE: a new op is accepted in the following IDLE cycle.
- `len`=0: one RUN cycle.
- `len`=NUM_BYTES-1: `idx` reaches its max without wrapping.
- Bytes above `len` remain 0.
- `ena`=0 in any state freezes state, `idx`, `cq`, `result`, and `done`. `done` stays high if it was high, and lasts exactly one enabled cycle.
- `rst_n` low at any time returns to IDLE immediately, including mid-operation.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0
  - `result`=0
  - `cout`=1, `cq`=1, `alu_cn`=1
  - `all_equal`=0
  - `alu_a`=`alu_b`=0, `alu_s`=0, `alu_m`=0
- Edge-by-edge sequence, with `start` sampled at edge E0:
  - RUN from E0.
  - Bytes captured at edges E1..E(len+1).
  - `done`=1 in the cycle after E(len+1).
  - IDLE after E(len+2).
- Latency from `start` to `done` is len+2 enabled cycles. Throughput is one op per len+3 cycles.
- The ALU path is combinational within one cycle: `alu_a`/`alu_b`/`alu_cn` → `alu_f`/`alu_cn8`/`alu_eq`. No multicycle paths.

## Configuration
- `ALU_SEQ_EQUAL_EN`
  - Defined: `all_equal` accumulates `alu_eq` as described.
  - Undefined: the `all_equal` register is not built, `all_equal` is tied to 0, and `alu_eq` is ignored.

## Test plan
- Add, no carry-in: S=1001, M=0, cin=1, len=3, A=0x000000FF, B=0x00000001 → `result`=0x00000100, `cout`=1. `done` appears 5 cycles after `start`.
- Add overflow: same op, A=0xFFFFFFFF, B=0x00000001 → `result`=0x00000000, `cout`=0.
- Equality via A−B−1: S=0110, M=0, cin=1, len=1, A=B=0x1234 → `result`=0xFFFF, `all_equal`=1. Repeat with B=0x1235 → `all_equal`=0. Undefine `ALU_SEQ_EQUAL_EN` → `all_equal`=0 in both cases.
- Logic XOR: S=0110, M=1, len=0, A=0xA5, B=0xFF → `result`=0x0000005A, `done` 2 cycles after `start`.
- `start` pulsed again during RUN with different operands → ignored, first result intact.
- `ena` low for 3 cycles mid-RUN → `done` delayed by exactly 3 cycles with the same result.
- `rst_n` asserted mid-RUN → immediate IDLE, `busy`=0, `result`=0.
- `start` held high continuously → back-to-back ops every len+3 cycles.
